seq_step_counter: RTL and testbench

Parametrised sequence stepper: a WIDTH-bit register advances, one step per enabled clock, to the next or previous member of a selectable number set: primes, Fibonacci numbers, perfect squares or all integers. Direction is selectable. The end of the set either wraps or saturates. The register can be loaded synchronously. It is the general-width successor of the 6-bit prime/Fibonacci T-flip-flop counter and sits in the same counter/sequence-generator layer of the design.

---
 rtl/seq_step_pkg.sv | 88 ++++++++
 rtl/seq_step_next.sv | 56 +++++
 rtl/seq_step_counter.sv | 87 ++++++++
 tb/tb_seq_step_counter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_step_pkg.sv
// Shared mode encoding and number-set helpers for the sequence stepper.
// All functions are constant-evaluable and bounded by the 8-bit maximum width.
package seq_step_pkg;

   localparam logic [1:0] MODE_PRIME = 2'b00;
   localparam logic [1:0] MODE_FIB   = 2'b01;
   localparam logic [1:0] MODE_SQR   = 2'b10;
   localparam logic [1:0] MODE_BIN   = 2'b11;

   localparam int MAX_WIDTH = 8;
   localparam int MAX_VALS  = 1 << MAX_WIDTH;

   // Trial division up to sqrt(255) is enough for every legal width.
   function automatic logic is_prime(input int v);
      logic p;
      p = (v >= 2);
      for (int d = 2; d < 16; d++) begin
         if ((d * d <= v) && ((v % d) == 0)) p = 1'b0;
      end
      return p;
   endfunction

   function automatic logic is_fib(input int v);
      int   a;
      int   b;
      int   t;
      logic f;
      a = 0;
      b = 1;
      f = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (a == v) f = 1'b1;
         t = a + b;
         a = b;
         b = t;
      end
      return f;
   endfunction

   function automatic logic is_square(input int v);
      logic s;
      s = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i * i == v) s = 1'b1;
      end
      return s;
   endfunction

   function automatic logic is_member(input int v, input logic [1:0] mode);
      logic m;
      case (mode)
         MODE_PRIME: m = is_prime(v);
         MODE_FIB:   m = is_fib(v);
         MODE_SQR:   m = is_square(v);
         default:    m = 1'b1;
      endcase
      return m;
   endfunction

   function automatic logic [MAX_VALS-1:0] member_table(input logic [1:0] mode,
                                                        input int width);
      logic [MAX_VALS-1:0] t;
      t = '0;
      for (int v = 0; v < MAX_VALS; v++) begin
         if (v < (1 << width)) t[v] = is_member(v, mode);
      end
      return t;
   endfunction

   function automatic int min_member(input logic [1:0] mode, input int width);
      int m;
      m = 0;
      for (int v = MAX_VALS - 1; v >= 0; v--) begin
         if ((v < (1 << width)) && is_member(v, mode)) m = v;
      end
      return m;
   endfunction

   function automatic int max_member(input logic [1:0] mode, input int width);
      int m;
      m = 0;
      for (int v = 0; v < MAX_VALS; v++) begin
         if ((v < (1 << width)) && is_member(v, mode)) m = v;
      end
      return m;
   endfunction

endpackage

// File: rtl/seq_step_next.sv
// Combinational neighbour search: nearest set member strictly above (ud=0)
// or strictly below (ud=1) the current count; no_member flags a set end.
module seq_step_next
   import seq_step_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input  logic [WIDTH-1:0] count,
   input  logic [1:0]       mode,
   input  logic             ud,
   output logic [WIDTH-1:0] next_val,
   output logic             no_member
);

   localparam int N = 1 << WIDTH;

   localparam logic [MAX_VALS-1:0] TAB_PRIME = member_table(MODE_PRIME, WIDTH);
   localparam logic [MAX_VALS-1:0] TAB_FIB   = member_table(MODE_FIB,   WIDTH);
   localparam logic [MAX_VALS-1:0] TAB_SQR   = member_table(MODE_SQR,   WIDTH);
   localparam logic [MAX_VALS-1:0] TAB_BIN   = member_table(MODE_BIN,   WIDTH);

   logic [N-1:0] tab;
   int           cnt_i;

   always_comb begin
      case (mode)
         MODE_PRIME: tab = TAB_PRIME[N-1:0];
         MODE_FIB:   tab = TAB_FIB[N-1:0];
         MODE_SQR:   tab = TAB_SQR[N-1:0];
         default:    tab = TAB_BIN[N-1:0];
      endcase
   end

   // Scan order makes the last hit the closest neighbour in each direction.
   always_comb begin
      cnt_i     = int'(count);
      next_val  = count;
      no_member = 1'b1;
      if (!ud) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (tab[i[WIDTH-1:0]] && (i > cnt_i)) begin
               next_val  = i[WIDTH-1:0];
               no_member = 1'b0;
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (tab[i[WIDTH-1:0]] && (i < cnt_i)) begin
               next_val  = i[WIDTH-1:0];
               no_member = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/seq_step_counter.sv
// Sequence stepper over primes, Fibonacci numbers, squares or all integers,
// with up/down stepping, wrap-or-saturate at set ends and synchronous load.
module seq_step_counter
   import seq_step_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             ud,
   input  logic [1:0]       mode,
   input  logic             wrap_en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             wrapped,
   output logic             at_limit,
   output logic             member
);

   localparam int N = 1 << WIDTH;

   localparam logic [MAX_VALS-1:0] TAB_PRIME = member_table(MODE_PRIME, WIDTH);
   localparam logic [MAX_VALS-1:0] TAB_FIB   = member_table(MODE_FIB,   WIDTH);
   localparam logic [MAX_VALS-1:0] TAB_SQR   = member_table(MODE_SQR,   WIDTH);
   localparam logic [MAX_VALS-1:0] TAB_BIN   = member_table(MODE_BIN,   WIDTH);

   localparam logic [WIDTH-1:0] MIN_PRIME = WIDTH'(min_member(MODE_PRIME, WIDTH));
   localparam logic [WIDTH-1:0] MIN_FIB   = WIDTH'(min_member(MODE_FIB,   WIDTH));
   localparam logic [WIDTH-1:0] MIN_SQR   = WIDTH'(min_member(MODE_SQR,   WIDTH));
   localparam logic [WIDTH-1:0] MIN_BIN   = WIDTH'(min_member(MODE_BIN,   WIDTH));
   localparam logic [WIDTH-1:0] MAX_PRIME = WIDTH'(max_member(MODE_PRIME, WIDTH));
   localparam logic [WIDTH-1:0] MAX_FIB   = WIDTH'(max_member(MODE_FIB,   WIDTH));
   localparam logic [WIDTH-1:0] MAX_SQR   = WIDTH'(max_member(MODE_SQR,   WIDTH));
   localparam logic [WIDTH-1:0] MAX_BIN   = WIDTH'(max_member(MODE_BIN,   WIDTH));

   logic [N-1:0]     tab;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] next_val;
   logic             no_member;

   always_comb begin
      case (mode)
         MODE_PRIME: begin tab = TAB_PRIME[N-1:0]; lo = MIN_PRIME; hi = MAX_PRIME; end
         MODE_FIB:   begin tab = TAB_FIB[N-1:0];   lo = MIN_FIB;   hi = MAX_FIB;   end
         MODE_SQR:   begin tab = TAB_SQR[N-1:0];   lo = MIN_SQR;   hi = MAX_SQR;   end
         default:    begin tab = TAB_BIN[N-1:0];   lo = MIN_BIN;   hi = MAX_BIN;   end
      endcase
   end

   assign member   = tab[count];
   assign at_limit = (count == (ud ? lo : hi));

   seq_step_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .count     (count),
      .mode      (mode),
      .ud        (ud),
      .next_val  (next_val),
      .no_member (no_member)
   );

   // Past a set end the wrap target is the opposite extreme of the set.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count   <= '0;
         wrapped <= 1'b0;
      end else if (load) begin
         count   <= load_val;
         wrapped <= 1'b0;
      end else if (en) begin
         wrapped <= 1'b0;
         if (!no_member) begin
            count <= next_val;
         end else if (wrap_en) begin
            count   <= ud ? hi : lo;
            wrapped <= 1'b1;
         end
      end else begin
         wrapped <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seq_step_counter.sv
// Scoreboard bench for seq_step_counter at WIDTH=6: directed sequences plus
// random traffic, checked against sorted member lists built from first principles.
module tb_seq_step_counter;

   localparam int WIDTH = 6;
   localparam int N     = 1 << WIDTH;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             en = 1'b0;
   logic             ud = 1'b0;
   logic [1:0]       mode = 2'b00;
   logic             wrap_en = 1'b0;
   logic             load = 1'b0;
   logic [WIDTH-1:0] load_val = '0;
   logic [WIDTH-1:0] count;
   logic             wrapped;
   logic             at_limit;
   logic             member;

   typedef struct {
      int   cnt;
      logic wr;
      logic mem;
      logic lim;
   } exp_t;

   exp_t sb[$];
   int   set_q[4][$];
   int   m_count = 0;
   int   checks = 0;
   int   errors = 0;

   seq_step_counter #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .ud       (ud),
      .mode     (mode),
      .wrap_en  (wrap_en),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .wrapped  (wrapped),
      .at_limit (at_limit),
      .member   (member)
   );

   always #5 clk = ~clk;

   function automatic logic in_set(input int m, input int v);
      for (int i = 0; i < set_q[m].size(); i++) if (set_q[m][i] == v) return 1'b1;
      return 1'b0;
   endfunction

   task automatic build_sets();
      int a;
      int b;
      int t;
      logic p;
      for (int v = 0; v < N; v++) begin
         p = (v >= 2);
         for (int d = 2; d < v; d++) if (v % d == 0) p = 1'b0;
         if (p) set_q[0].push_back(v);
      end
      a = 0;
      b = 1;
      while (a < N) begin
         if (set_q[1].size() == 0 || set_q[1][set_q[1].size()-1] != a) set_q[1].push_back(a);
         t = a + b;
         a = b;
         b = t;
      end
      for (int i = 0; i * i < N; i++) set_q[2].push_back(i * i);
      for (int v = 0; v < N; v++) set_q[3].push_back(v);
   endtask

   task automatic step(input logic r, input logic ld, input int lv, input logic e,
                       input logic u, input int md, input logic we);
      int   nxt;
      int   sz;
      logic wr;
      exp_t x;
      @(negedge clk);
      rst      = r;
      load     = ld;
      load_val = lv[WIDTH-1:0];
      en       = e;
      ud       = u;
      mode     = md[1:0];
      wrap_en  = we;
      wr       = 1'b0;
      sz       = set_q[md].size();
      if (!r) begin
         m_count = 0;
      end else if (ld) begin
         m_count = lv;
      end else if (e) begin
         nxt = -1;
         if (!u) begin
            for (int i = 0; i < sz; i++)
               if (nxt < 0 && set_q[md][i] > m_count) nxt = set_q[md][i];
         end else begin
            for (int i = sz - 1; i >= 0; i--)
               if (nxt < 0 && set_q[md][i] < m_count) nxt = set_q[md][i];
         end
         if (nxt >= 0) begin
            m_count = nxt;
         end else if (we) begin
            m_count = u ? set_q[md][sz-1] : set_q[md][0];
            wr = 1'b1;
         end
      end
      x.cnt = m_count;
      x.wr  = wr;
      x.mem = in_set(md, m_count);
      x.lim = (m_count == (u ? set_q[md][0] : set_q[md][sz-1]));
      sb.push_back(x);
   endtask

   // Monitor: one expectation per clock, compared just after the active edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            if (int'(count) != x.cnt) begin
               errors++;
               $display("FAIL count got=%0d exp=%0d t=%0t", count, x.cnt, $time);
            end
            checks++;
            if (wrapped !== x.wr) begin
               errors++;
               $display("FAIL wrapped got=%0b exp=%0b t=%0t", wrapped, x.wr, $time);
            end
            checks++;
            if (member !== x.mem) begin
               errors++;
               $display("FAIL member got=%0b exp=%0b t=%0t", member, x.mem, $time);
            end
            checks++;
            if (at_limit !== x.lim) begin
               errors++;
               $display("FAIL at_limit got=%0b exp=%0b t=%0t", at_limit, x.lim, $time);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic r_u;
      logic r_we;
      int   r_md;
      build_sets();
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0, 0, 1);
      // Prime up with wrap: 0,2,...,61 then 2 with a wrap pulse
      for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 1);
      // Fibonacci down from reset: wrap to 55, descend to 0, wrap again
      step(0, 0, 0, 0, 1, 1, 1);
      for (int i = 0; i < 12; i++) step(1, 0, 0, 1, 1, 1, 1);
      // Fibonacci up saturating at 55
      step(1, 1, 55, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 1, 0);
      // Squares: 10 -> 16 -> 9, load beats en, then 40 -> 49
      step(1, 1, 10, 0, 0, 2, 1);
      step(1, 0, 0, 1, 0, 2, 1);
      step(1, 0, 0, 1, 1, 2, 1);
      step(1, 1, 40, 1, 0, 2, 1);
      step(1, 0, 0, 1, 0, 2, 1);
      step(1, 0, 0, 1, 0, 2, 1);
      // Binary down from 0: wrap to 63, then saturate at 0
      step(0, 0, 0, 0, 1, 3, 1);
      step(1, 0, 0, 1, 1, 3, 1);
      step(0, 0, 0, 0, 1, 3, 0);
      step(1, 0, 0, 1, 1, 3, 0);
      step(1, 0, 0, 1, 1, 3, 0);
      // Mid-run reset with en high, then mode switch at 7
      step(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0, 1);
      step(0, 0, 0, 1, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0, 0, 1);
      step(1, 0, 0, 1, 0, 1, 1);
      // Prime down saturating at 2, loaded non-member 1 snaps/holds
      step(1, 1, 3, 0, 1, 0, 0);
      step(1, 0, 0, 1, 1, 0, 0);
      step(1, 0, 0, 1, 1, 0, 0);
      step(1, 1, 1, 0, 1, 0, 0);
      step(1, 0, 0, 1, 1, 0, 0);
      step(1, 0, 0, 1, 0, 0, 0);
      // Random traffic with sticky direction/mode so set ends are reached
      r_u  = 1'b0;
      r_we = 1'b1;
      r_md = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) r_u  = ~r_u;
         if ($urandom_range(0, 19) == 0) r_we = ~r_we;
         if ($urandom_range(0, 24) == 0) r_md = int'($urandom_range(0, 3));
         step($urandom_range(0, 59) != 0, $urandom_range(0, 19) == 0,
              int'($urandom_range(0, N - 1)), $urandom_range(0, 4) != 0,
              r_u, r_md, r_we);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
